// File: rtl/master_req_ctrl_if.sv
// Command, interconnect-request and response signals of the master request controller.
// The master modport is the controller's view; the slave modport is the environment's view.
interface master_req_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_wr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata_in;
    logic              sfor;
    logic [1:0]        req_stat;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wr, cmd_wdata, ack, rdata_in,
        output cmd_ready, sfor, req_stat, req_addr, req_wr, req_wdata,
               rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wr, cmd_wdata, ack, rdata_in,
        input  cmd_ready, sfor, req_stat, req_addr, req_wr, req_wdata,
               rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/master_req_ctrl.sv
// Master-side request controller: one command at a time, routed via sfor/req_stat to the ack arbiter.
// Optional W_ACK abort timer is enabled by defining REQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a command (req_stat 0)
// SEND  | request presented for one cycle (req_stat 1)
// W_ACK | waiting for the routed ack (req_stat 2)
// RESP  | one-cycle response strobe (req_stat 3)
module master_req_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SLV_BIT = ADDR_W - 1,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    master_req_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        W_ACK = 2'd2,
        RESP  = 2'd3
    } state_t;

    if (SLV_BIT < 0 || SLV_BIT >= ADDR_W) begin : g_bad_slv_bit
        $error("master_req_ctrl: SLV_BIT %0d outside address width %0d", SLV_BIT, ADDR_W);
    end
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("master_req_ctrl: TIMEOUT %0d outside 2..65535", TIMEOUT);
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              sfor_q, sfor_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef REQ_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        sfor_d  = sfor_q;
        rdata_d = rdata_q;
`ifdef REQ_TIMEOUT_EN
        cnt_d   = '0;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    wr_d    = bus.cmd_wr;
                    wdata_d = bus.cmd_wdata;
                    sfor_d  = bus.cmd_addr[SLV_BIT];
                    state_d = SEND;
                end
            end
            SEND: state_d = W_ACK;
            W_ACK: begin
                // An ack on the final timer cycle still completes normally.
                if (bus.ack) begin
                    rdata_d = wr_q ? '0 : bus.rdata_in;
                    state_d = RESP;
`ifdef REQ_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
`endif
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            sfor_q  <= 1'b0;
            rdata_q <= '0;
`ifdef REQ_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            sfor_q  <= sfor_d;
            rdata_q <= rdata_d;
`ifdef REQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.req_stat  = state_q;
    assign bus.sfor      = sfor_q;
    assign bus.req_addr  = addr_q;
    assign bus.req_wr    = wr_q;
    assign bus.req_wdata = wdata_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
`ifdef REQ_TIMEOUT_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule
